// File: rtl/io_uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state types for io_uart_dev.
package io_uart_pkg;

  // Register offsets within the four-word window
  localparam logic [1:0] RegData    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegDivisor = 2'd2;
  localparam logic [1:0] RegCtrl    = 2'd3;

  // STATUS bit positions
  localparam int unsigned StRxValid   = 0;
  localparam int unsigned StTxBusy    = 1;
  localparam int unsigned StTxEmpty   = 2;
  localparam int unsigned StTxFull    = 3;
  localparam int unsigned StRxOverrun = 4;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

  // Divisors below 2 would leave no room for a mid-bit sample, so clamp them
  function automatic logic [15:0] effDiv(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous show-ahead FIFO holding bytes waiting for the transmitter.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       notReset,
  input  logic       push,
  input  logic [7:0] pushData,
  input  logic       pop,
  output logic [7:0] popData,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wrPtrQ;
  logic [AW:0] rdPtrQ;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign full    = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
  assign empty   = (wrPtrQ == rdPtrQ);
  assign popData = mem[rdPtrQ[AW-1:0]];

  // Storage write; a push into a full FIFO is dropped
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wrPtrQ[AW-1:0]] <= pushData;
    end
  end

  // Pointer update
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
    end else begin
      if (push && !full) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop && !empty) rdPtrQ <= rdPtrQ + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart_dev.sv
// Memory-mapped 8N1 UART: zero-wait-state register decode, TX FIFO + TX FSM, RX FSM.
module io_uart_dev
  import io_uart_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd104
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic [14:0] address,
  inout  wire  [15:0] data,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  input  logic        csl_n,
  input  logic        csh_n,
  input  logic        select_dev,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  logic        hit, wrFire, rdFire, wrPrevQ, rdPrevQ;
  logic [1:0]  regOff;
  logic [15:0] divQ, divEff, rxHalf, readWord;
  logic        rxIrqEnQ, txIrqEnQ;
  logic        txPush, rxPop, clrOverrun;
  logic        txPop, txFull, txEmpty, txBusy;
  logic [7:0]  txHead;

  tx_state_t   txStateQ;
  logic [15:0] txCntQ;
  logic [2:0]  txBitQ;
  logic [7:0]  txShiftQ;

  rx_state_t   rxStateQ;
  logic [15:0] rxCntQ;
  logic [2:0]  rxBitQ;
  logic [7:0]  rxShiftQ, rxByteQ;
  logic        rxSync1Q, rxSync2Q, rxPrevQ, rxValidQ, rxOverrunQ;

  assign hit    = select_dev & (address[14:2] == BASE_ADDR[14:2]);
  assign regOff = address[1:0];
  // Side effects fire only on the first selected cycle of each strobe
  assign wrFire = hit & ~memNotWrite & wrPrevQ;
  assign rdFire = hit & ~memNotRead & rdPrevQ;

  assign txPush     = wrFire & (regOff == RegData) & ~csl_n;
  assign rxPop      = rdFire & (regOff == RegData) & ~csl_n;
  assign clrOverrun = wrFire & (regOff == RegCtrl) & ~csl_n & data[2];

  assign divEff = effDiv(divQ);
  assign rxHalf = (divEff >> 1) - 16'd1;
  assign txBusy = (txStateQ != TxIdle);

  // Strobe history for once-per-access side effects
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      wrPrevQ <= 1'b1;
      rdPrevQ <= 1'b1;
    end else begin
      wrPrevQ <= memNotWrite;
      rdPrevQ <= memNotRead;
    end
  end

  // DIVISOR (per-lane) and CTRL register writes
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      divQ     <= DIV_RESET;
      rxIrqEnQ <= 1'b0;
      txIrqEnQ <= 1'b0;
    end else if (wrFire) begin
      if (regOff == RegDivisor) begin
        if (!csl_n) divQ[7:0]  <= data[7:0];
        if (!csh_n) divQ[15:8] <= data[15:8];
      end
      if (regOff == RegCtrl && !csl_n) begin
        rxIrqEnQ <= data[0];
        txIrqEnQ <= data[1];
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    readWord = '0;
    unique case (regOff)
      RegData:    readWord = {8'h00, rxByteQ};
      RegStatus:  readWord = {11'b0, rxOverrunQ, txFull, txEmpty, txBusy, rxValidQ};
      RegDivisor: readWord = divQ;
      RegCtrl:    readWord = {14'b0, txIrqEnQ, rxIrqEnQ};
      default:    readWord = '0;
    endcase
  end

  assign data[7:0]  = (hit & ~memNotRead & ~csl_n) ? readWord[7:0]  : 8'hzz;
  assign data[15:8] = (hit & ~memNotRead & ~csh_n) ? readWord[15:8] : 8'hzz;

  uart_tx_fifo #(
    .DEPTH(TX_DEPTH)
  ) uTxFifo (
    .clock   (clock),
    .notReset(notReset),
    .push    (txPush),
    .pushData(data[7:0]),
    .pop     (txPop),
    .popData (txHead),
    .full    (txFull),
    .empty   (txEmpty)
  );

  // Pop exactly when the TX FSM loads a new byte into its shifter
  assign txPop = ~txEmpty & ((txStateQ == TxIdle) | ((txStateQ == TxStop) & (txCntQ == 16'd0)));

  // TX FSM; each state lasts divEff clocks, latched on entry
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      txStateQ <= TxIdle;
      txCntQ   <= '0;
      txBitQ   <= '0;
      txShiftQ <= '0;
      txd      <= 1'b1;
    end else begin
      unique case (txStateQ)
        TxIdle: if (!txEmpty) begin
          txStateQ <= TxStart;
          txShiftQ <= txHead;
          txCntQ   <= divEff - 16'd1;
          txd      <= 1'b0;
        end
        TxStart: if (txCntQ == 16'd0) begin
          txStateQ <= TxData;
          txBitQ   <= '0;
          txCntQ   <= divEff - 16'd1;
          txd      <= txShiftQ[0];
        end else txCntQ <= txCntQ - 16'd1;
        TxData: if (txCntQ == 16'd0) begin
          txCntQ <= divEff - 16'd1;
          if (txBitQ == 3'd7) begin
            txStateQ <= TxStop;
            txd      <= 1'b1;
          end else begin
            txBitQ   <= txBitQ + 3'd1;
            txShiftQ <= txShiftQ >> 1;
            txd      <= txShiftQ[1];
          end
        end else txCntQ <= txCntQ - 16'd1;
        TxStop: if (txCntQ == 16'd0) begin
          if (!txEmpty) begin
            txStateQ <= TxStart;
            txShiftQ <= txHead;
            txCntQ   <= divEff - 16'd1;
            txd      <= 1'b0;
          end else txStateQ <= TxIdle;
        end else txCntQ <= txCntQ - 16'd1;
        default: txStateQ <= TxIdle;
      endcase
    end
  end

  // RX synchroniser, RX FSM and holding register; completion overrides a same-edge pop
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      rxSync1Q   <= 1'b1;
      rxSync2Q   <= 1'b1;
      rxPrevQ    <= 1'b1;
      rxStateQ   <= RxIdle;
      rxCntQ     <= '0;
      rxBitQ     <= '0;
      rxShiftQ   <= '0;
      rxByteQ    <= '0;
      rxValidQ   <= 1'b0;
      rxOverrunQ <= 1'b0;
    end else begin
      rxSync1Q <= rxd;
      rxSync2Q <= rxSync1Q;
      rxPrevQ  <= rxSync2Q;
      if (rxPop) rxValidQ <= 1'b0;
      if (clrOverrun) rxOverrunQ <= 1'b0;
      unique case (rxStateQ)
        RxIdle: if (rxPrevQ && !rxSync2Q) begin
          rxStateQ <= RxStart;
          rxCntQ   <= rxHalf;
        end
        RxStart: if (rxCntQ == 16'd0) begin
          if (rxSync2Q) rxStateQ <= RxIdle;
          else begin
            rxStateQ <= RxData;
            rxBitQ   <= '0;
            rxCntQ   <= divEff - 16'd1;
          end
        end else rxCntQ <= rxCntQ - 16'd1;
        RxData: if (rxCntQ == 16'd0) begin
          rxShiftQ <= {rxSync2Q, rxShiftQ[7:1]};
          rxCntQ   <= divEff - 16'd1;
          if (rxBitQ == 3'd7) rxStateQ <= RxStop;
          else rxBitQ <= rxBitQ + 3'd1;
        end else rxCntQ <= rxCntQ - 16'd1;
        RxStop: if (rxCntQ == 16'd0) begin
          rxStateQ <= RxIdle;
          if (rxSync2Q) begin
            rxByteQ  <= rxShiftQ;
            rxValidQ <= 1'b1;
            if (rxValidQ && !rxPop) rxOverrunQ <= 1'b1;
          end
        end else rxCntQ <= rxCntQ - 16'd1;
        default: rxStateQ <= RxIdle;
      endcase
    end
  end

  assign irq = (rxIrqEnQ & rxValidQ) | (txIrqEnQ & txEmpty & ~txBusy);

endmodule
